// File: rtl/menu_selector_if.sv
// rtl/menu_selector_if.sv - button, song-done and menu output bundle for menu_selector
interface menu_selector_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_confirm;
    logic       btn_back;
    logic       song_done;
    logic [2:0] state;
    logic [2:0] song;
    logic [1:0] phase;
    logic       play_start;

    modport master (
        output btn_up, btn_down, btn_confirm, btn_back, song_done,
        input  state, song, phase, play_start
    );

    modport slave (
        input  btn_up, btn_down, btn_confirm, btn_back, song_done,
        output state, song, phase, play_start
    );
endinterface

// File: rtl/menu_selector.sv
// rtl/menu_selector.sv - debounced four-button menu FSM selecting mode and song
module menu_selector #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_SONGS       = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    menu_selector_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    SONG_MAX = 3'(NUM_SONGS - 1);

    localparam logic [2:0] FREE_MODE = 3'd0;
    localparam logic [2:0] AUTO_MODE = 3'd1;
    localparam logic [2:0] STDY_MODE = 3'd2;
    localparam logic [2:0] PLAY_MODE = 3'd3;
    localparam logic [2:0] SET_MODE  = 3'd4;

    typedef enum logic [1:0] {
        BROWSE   = 2'd0,
        SONG_SEL = 2'd1,
        RUN      = 2'd2
    } phase_e;

    // Button index: 0 down, 1 up, 2 confirm, 3 back
    logic [3:0] raw_btn;
    logic [3:0] press_q;
    assign raw_btn = {bus.btn_back, bus.btn_confirm, bus.btn_up, bus.btn_down};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic          sync1_q, sync2_q, deb_q, armed_q;
        logic [CW-1:0] deb_cnt_q, arm_cnt_q;

        // Arming needs a debounced-length stretch of low input, so a button
        // held through reset cannot arm on the reset-cleared synchronizer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                armed_q    <= 1'b0;
                deb_cnt_q  <= '0;
                arm_cnt_q  <= '0;
                press_q[i] <= 1'b0;
            end else begin
                sync1_q    <= raw_btn[i];
                sync2_q    <= sync1_q;
                press_q[i] <= 1'b0;
                if (sync2_q != deb_q) begin
                    if (deb_cnt_q == CNT_MAX) begin
                        deb_q      <= sync2_q;
                        deb_cnt_q  <= '0;
                        press_q[i] <= sync2_q & armed_q;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end else begin
                    deb_cnt_q <= '0;
                end
                if (!armed_q) begin
                    if (!sync2_q && !deb_q) begin
                        if (arm_cnt_q == CNT_MAX) armed_q <= 1'b1;
                        else                      arm_cnt_q <= arm_cnt_q + 1'b1;
                    end else begin
                        arm_cnt_q <= '0;
                    end
                end
            end
        end
    end

    phase_e     phase_q, phase_d;
    logic [2:0] state_q, state_d;
    logic [2:0] song_q, song_d;
    logic       play_start_q, play_start_d;
    logic       pend_q, pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= BROWSE;
            state_q      <= FREE_MODE;
            song_q       <= 3'd0;
            play_start_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            state_q      <= state_d;
            song_q       <= song_d;
            play_start_q <= play_start_d;
            pend_q       <= pend_d;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        state_d      = state_q;
        song_d       = song_q;
        play_start_d = 1'b0;
        pend_d       = 1'b0;
        case (phase_q)
            BROWSE: begin
                if (press_q[3]) begin
                    phase_d = BROWSE;
                end else if (press_q[2]) begin
                    if (state_q == AUTO_MODE || state_q == STDY_MODE || state_q == PLAY_MODE)
                        phase_d = SONG_SEL;
                    else
                        phase_d = RUN;
                end else if (press_q[1]) begin
                    state_d = (state_q >= SET_MODE) ? FREE_MODE : state_q + 3'd1;
                end else if (press_q[0]) begin
                    state_d = (state_q == FREE_MODE || state_q > SET_MODE) ? SET_MODE : state_q - 3'd1;
                end
            end
            SONG_SEL: begin
                if (press_q[3]) begin
                    phase_d = BROWSE;
                end else if (press_q[2]) begin
                    phase_d      = RUN;
                    play_start_d = 1'b1;
                end else if (press_q[1]) begin
                    song_d = (song_q >= SONG_MAX) ? 3'd0 : song_q + 3'd1;
                end else if (press_q[0]) begin
                    song_d = (song_q == 3'd0 || song_q > SONG_MAX) ? SONG_MAX : song_q - 3'd1;
                end
            end
            RUN: begin
                if (press_q[3]) begin
                    phase_d = BROWSE;
                end else begin
                    play_start_d = pend_q;
                    if (bus.song_done) begin
                        if (state_q == AUTO_MODE) begin
                            song_d = (song_q >= SONG_MAX) ? 3'd0 : song_q + 3'd1;
                            pend_d = 1'b1;
                        end else if (state_q == STDY_MODE || state_q == PLAY_MODE) begin
                            phase_d = SONG_SEL;
                        end
                    end
                end
            end
            default: phase_d = BROWSE;
        endcase
    end

    assign bus.state      = state_q;
    assign bus.song       = song_q;
    assign bus.phase      = phase_q;
    assign bus.play_start = play_start_q;
endmodule

// File: tb/tb_menu_selector.sv
// tb/tb_menu_selector.sv - directed self-checking bench for menu_selector
module tb_menu_selector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] btn_v = 4'b0000;
    int compared = 0;
    int mismatched = 0;
    int ps_cnt = 0;
    int ps_mark;

    always #5 clk = ~clk;

    menu_selector_if ifc ();
    assign ifc.btn_down    = btn_v[0];
    assign ifc.btn_up      = btn_v[1];
    assign ifc.btn_confirm = btn_v[2];
    assign ifc.btn_back    = btn_v[3];

    menu_selector #(.DEBOUNCE_CYCLES(4), .NUM_SONGS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always @(negedge clk) if (ifc.play_start === 1'b1) ps_cnt++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx);
        btn_v[idx] = 1'b1;
        tick(10);
        btn_v[idx] = 1'b0;
        tick(10);
    endtask

    task automatic pulse_done();
        ifc.song_done = 1'b1;
        tick(1);
        ifc.song_done = 1'b0;
        tick(4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input logic [2:0] sg, input logic [1:0] ph);
        chk({tag, "_state"}, {5'd0, ifc.state}, {5'd0, st});
        chk({tag, "_song"},  {5'd0, ifc.song},  {5'd0, sg});
        chk({tag, "_phase"}, {6'd0, ifc.phase}, {6'd0, ph});
    endtask

    initial begin
        ifc.song_done = 1'b0;
        tick(3);
        chk_out("rst", 3'd0, 3'd0, 2'd0);
        chk("rst_play_start", {7'd0, ifc.play_start}, 8'd0);
        rst_n = 1'b1;
        tick(10);

        // Single clean up press
        press(1);
        chk_out("up1", 3'd1, 3'd0, 2'd0);
        chk("up1_no_start", 8'(ps_cnt), 8'd0);

        // Bouncing input never settles long enough
        for (int i = 0; i < 20; i++) begin
            btn_v[1] = ~btn_v[1];
            tick(2);
        end
        btn_v[1] = 1'b0;
        tick(10);
        chk("bounce_state", {5'd0, ifc.state}, 8'd1);

        do_reset();
        press(1); chk("walk1", {5'd0, ifc.state}, 8'd1);
        press(1); chk("walk2", {5'd0, ifc.state}, 8'd2);
        press(1); chk("walk3", {5'd0, ifc.state}, 8'd3);
        press(1); chk("walk4", {5'd0, ifc.state}, 8'd4);
        press(1); chk("walk_wrap", {5'd0, ifc.state}, 8'd0);
        press(0); chk("down_wrap", {5'd0, ifc.state}, 8'd4);

        // Song selection from auto mode
        press(1);
        press(1);
        chk("to_auto", {5'd0, ifc.state}, 8'd1);
        press(2); chk_out("sel", 3'd1, 3'd0, 2'd1);
        press(1); chk("song_up", {5'd0, ifc.song}, 8'd1);
        press(1); chk("song_wrap", {5'd0, ifc.song}, 8'd0);
        press(1);
        ps_mark = ps_cnt;
        press(2);
        chk_out("run", 3'd1, 3'd1, 2'd2);
        chk("run_start_once", 8'(ps_cnt - ps_mark), 8'd1);

        // Auto mode advances song on song_done
        ps_mark = ps_cnt;
        pulse_done();
        chk_out("auto_done", 3'd1, 3'd0, 2'd2);
        chk("auto_done_start", 8'(ps_cnt - ps_mark), 8'd1);

        // Steady mode returns to song selection
        press(3); chk_out("back_run", 3'd1, 3'd0, 2'd0);
        press(1);
        press(2); chk("stdy_sel", {6'd0, ifc.phase}, 8'd1);
        ps_mark = ps_cnt;
        press(2);
        chk("stdy_run", {6'd0, ifc.phase}, 8'd2);
        chk("stdy_run_start", 8'(ps_cnt - ps_mark), 8'd1);
        ps_mark = ps_cnt;
        pulse_done();
        chk_out("stdy_done", 3'd2, 3'd0, 2'd1);
        chk("stdy_done_no_start", 8'(ps_cnt - ps_mark), 8'd0);

        // Simultaneous back and confirm: back wins
        btn_v = 4'b1100;
        tick(10);
        btn_v = 4'b0000;
        tick(10);
        chk_out("simul", 3'd2, 3'd0, 2'd0);

        // Confirm held through reset release
        btn_v[2] = 1'b1;
        do_reset();
        tick(20);
        chk_out("held", 3'd0, 3'd0, 2'd0);
        btn_v[2] = 1'b0;
        tick(20);
        chk("held_release", {6'd0, ifc.phase}, 8'd0);
        ps_mark = ps_cnt;
        press(2);
        chk_out("free_run", 3'd0, 3'd0, 2'd2);
        pulse_done();
        chk_out("free_done", 3'd0, 3'd0, 2'd2);
        chk("free_no_start", 8'(ps_cnt - ps_mark), 8'd0);

        // Reach a non-trivial RUN, then reset mid-debounce of back
        press(3);
        press(1);
        press(2);
        press(1);
        press(2);
        chk_out("pre_rst", 3'd1, 3'd1, 2'd2);
        btn_v[3] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 3'd0, 3'd0, 2'd0);
        chk("async_rst_ps", {7'd0, ifc.play_start}, 8'd0);
        btn_v[3] = 1'b0;
        tick(3);
        ps_mark = ps_cnt;
        rst_n = 1'b1;
        tick(30);
        chk_out("post_rst", 3'd0, 3'd0, 2'd0);
        chk("post_rst_ps", 8'(ps_cnt - ps_mark), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
